opl3_sample_fifo: RTL
=====================

Name: opl3_sample_fifo

Overview:
Downstream of the channel accumulator stage. Captures each clamped stereo sample pulse (channel_valid, channel_l, channel_r) into a small FIFO. The FIFO hands samples to a consumer, such as the SB mixer or I2S serializer, over a valid/ready handshake in the same clock domain. It absorbs consumer back-pressure jitter, applies a defined overflow policy, and keeps saturating overflow and underrun statistics.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2.
STAT_WIDTH, 8, width of the saturating overflow and underrun counters.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
channel_valid  in  1  one-cycle pulse; a new stereo sample is present
channel_l  in  SAMPLE_WIDTH  signed left sample
channel_r  in  SAMPLE_WIDTH  signed right sample
out_valid  out  1  out_l/out_r hold a valid sample
out_ready  in  1  consumer accepts the sample when out_valid && out_ready
out_l  out  SAMPLE_WIDTH  signed left output
out_r  out  SAMPLE_WIDTH  signed right output
level  out  $clog2(DEPTH)+1  number of stored entries, including the output register
overflow  out  1  sticky; set when a sample is dropped
overflow_count  out  STAT_WIDTH  dropped samples, saturating
underrun_count  out  STAT_WIDTH  cycles with out_ready && !out_valid, saturating
clr_stats  in  1  pulse; clears overflow, overflow_count and underrun_count

Behaviour:
- Reset values:
  - out_valid=0, out_l=out_r=0, level=0.
  - overflow=0, both counters=0.
  - Read and write pointers=0.
  - Reset mid-transfer discards all contents on the next edge.
- Structure:
  - Circular buffer of DEPTH-1 entries feeding one registered output slot (out_l/out_r/out_valid).
  - Total capacity is DEPTH.
- Pointers:
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH-1 storage entries.
  - Full/empty is decided by an explicit occupancy counter, not by pointer compare.
- Latency: a sample written when the FIFO is fully empty appears with out_valid=1 on the cycle after the channel_valid pulse.
- Fall-through path: if the output slot is empty, or is being drained this cycle with storage empty, the input goes straight to the output register.
- Handshake:
  - out_l/out_r stay stable while out_valid && !out_ready.
  - On acceptance, the next stored entry loads on the following edge (no bubble). If none is stored, out_valid drops to 0.
- Full (level==DEPTH):
  - A channel_valid without a same-cycle pop is dropped (newest sample is discarded).
  - The drop sets overflow and increments overflow_count (saturates at all-ones).
- Full with a same-cycle pop: the sample is accepted with no drop, and level stays at DEPTH.
- Empty with out_ready=1: underrun_count increments by 1 per cycle (saturating). The output holds its last data with out_valid=0; data content is don't-care.
- level arithmetic: +1 per accepted write, -1 per pop, net 0 when both happen in one cycle. Never exceeds DEPTH, never goes below 0.
- clr_stats coinciding with a drop or underrun event: the clear wins, and the counter reads 0.
- Samples are passed unmodified; no clamping, scaling or sign extension is done here.

Decomposition:
- opl3_pkg:
  - SAMPLE_WIDTH (existing).
  - New packed struct stereo_sample_t {l, r}, each SAMPLE_WIDTH signed.
  - OPL3_SAMPLE_FIFO_DEPTH default constant.
- One sub-module, sample_fifo_mem: simple dual-port storage.
  - Size (DEPTH-1) x 2*SAMPLE_WIDTH.
  - Synchronous write and registered read, one-cycle read latency.
  - Read latency is hidden by prefetch into the output slot.
- The top level holds the pointers, occupancy counter, output slot and stats.

Test Plan:
- Single sample:
  - Stimulus: reset, then channel_valid with L=16'h1234, R=16'hEDCC, out_ready=1.
  - Response: out_valid=1 one cycle later with the exact values; level goes 1 then 0; underrun_count increments every later idle cycle.
- Back-pressure:
  - Stimulus: out_ready=0, write 8 samples with values 1..8 (DEPTH=8).
  - Response: level=8, overflow=0.
  - Stimulus: raise out_ready.
  - Response: outputs 1..8 on consecutive cycles with no bubbles; out_valid drops after 8.
- Overflow:
  - Stimulus: FIFO full, out_ready=0, write samples 9 and 10.
  - Response: both dropped; overflow=1, overflow_count=2; drain yields exactly 1..8.
- Simultaneous push/pop at full:
  - Stimulus: level=8, channel_valid and out_ready in the same cycle.
  - Response: level stays 8, overflow_count unchanged; new sample appears in order after the existing 7.
- Saturation and clear:
  - Stimulus: 300 underrun cycles.
  - Response: underrun_count=255.
  - Stimulus: clr_stats pulse coinciding with an underrun cycle.
  - Response: count=0 next cycle.
- Reset mid-operation:
  - Stimulus: level=5 with out_valid=1, assert reset for 1 cycle.
  - Response: out_valid=0, level=0, stats=0; next write emerges after 1 cycle.

Source files
------------

// File: rtl/opl3_pkg.sv
// Shared OPL3 datapath types and constants.
package opl3_pkg;

    localparam int SAMPLE_WIDTH           = 16;
    localparam int OPL3_SAMPLE_FIFO_DEPTH = 8;

    typedef struct packed {
        logic signed [SAMPLE_WIDTH-1:0] l;
        logic signed [SAMPLE_WIDTH-1:0] r;
    } stereo_sample_t;

endpackage

// File: rtl/sample_fifo_mem.sv
// Simple dual-port sample storage, DEPTH-1 entries, synchronous write and registered read.
module sample_fifo_mem
    import opl3_pkg::*;
#(
    parameter int DEPTH = OPL3_SAMPLE_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]      wr_addr_i,
    input  logic [2*SAMPLE_WIDTH-1:0]     wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]      rd_addr_i,
    output logic [2*SAMPLE_WIDTH-1:0]     rd_data_o
);

    logic [2*SAMPLE_WIDTH-1:0] mem_q [DEPTH-1];
    logic [2*SAMPLE_WIDTH-1:0] rd_data_q;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read; a same-address write is forwarded so the read register never holds stale data.
    always_ff @(posedge clk) begin
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_q <= wr_data_i;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/opl3_sample_fifo.sv
// Stereo sample FIFO between the channel accumulator and the sample consumer,
// with a registered output slot, drop-newest overflow policy and saturating statistics.
module opl3_sample_fifo
    import opl3_pkg::*;
#(
    parameter int DEPTH      = OPL3_SAMPLE_FIFO_DEPTH,
    parameter int STAT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           channel_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] channel_l,
    input  logic signed [SAMPLE_WIDTH-1:0] channel_r,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [SAMPLE_WIDTH-1:0] out_l,
    output logic signed [SAMPLE_WIDTH-1:0] out_r,
    output logic [$clog2(DEPTH):0]         level,
    output logic                           overflow,
    output logic [STAT_WIDTH-1:0]          overflow_count,
    output logic [STAT_WIDTH-1:0]          underrun_count,
    input  logic                           clr_stats
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic [LW-1:0]         level_q, level_d;
    stereo_sample_t        out_q, out_d, in_s;
    logic                  out_valid_q, out_valid_d;
    logic                  overflow_q, overflow_d;
    logic [STAT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d, und_cnt_q, und_cnt_d;
    logic                  pop_s, full_s, accept_s, drop_s, underrun_s, mem_we_s;
    logic [2*SAMPLE_WIDTH-1:0] mem_rdata_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 2)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] c);
        return (&c) ? c : c + STAT_WIDTH'(1);
    endfunction

    assign in_s = {channel_l, channel_r};

    // Next-state for pointers, output slot, occupancy and statistics.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        ovf_cnt_d   = ovf_cnt_q;
        und_cnt_d   = und_cnt_q;
        mem_we_s    = 1'b0;

        pop_s      = out_valid_q & out_ready;
        full_s     = (level_q == LW'(DEPTH));
        accept_s   = channel_valid & (~full_s | pop_s);
        drop_s     = channel_valid & ~accept_s;
        underrun_s = out_ready & ~out_valid_q;

        if (!out_valid_q || pop_s) begin
            // Output slot is free at the edge: refill from storage first, else fall through.
            if (count_q != '0) begin
                out_d       = mem_rdata_s;
                out_valid_d = 1'b1;
                rd_ptr_d    = ptr_inc(rd_ptr_q);
                if (accept_s) begin
                    mem_we_s = 1'b1;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                end else begin
                    count_d = count_q - PW'(1);
                end
            end else if (accept_s) begin
                out_d       = in_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept_s) begin
            mem_we_s = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d  = count_q + PW'(1);
        end else begin
            count_d = count_q;
        end

        case ({accept_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (clr_stats) begin
            overflow_d = 1'b0;
            ovf_cnt_d  = '0;
            und_cnt_d  = '0;
        end else begin
            if (drop_s) begin
                overflow_d = 1'b1;
                ovf_cnt_d  = sat_inc(ovf_cnt_q);
            end else begin
                ovf_cnt_d = ovf_cnt_q;
            end
            if (underrun_s) begin
                und_cnt_d = sat_inc(und_cnt_q);
            end else begin
                und_cnt_d = und_cnt_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            level_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            ovf_cnt_q   <= '0;
            und_cnt_q   <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            level_q     <= level_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            ovf_cnt_q   <= ovf_cnt_d;
            und_cnt_q   <= und_cnt_d;
        end
    end

    // Read address tracks the next read pointer so the read register always holds the head entry.
    sample_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk       (clk),
        .wr_en_i   (mem_we_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_s),
        .rd_addr_i (rd_ptr_d),
        .rd_data_o (mem_rdata_s)
    );

    assign out_valid      = out_valid_q;
    assign out_l          = out_q.l;
    assign out_r          = out_q.r;
    assign level          = level_q;
    assign overflow       = overflow_q;
    assign overflow_count = ovf_cnt_q;
    assign underrun_count = und_cnt_q;

endmodule
